// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Receives a little-endian byte stream, packs it into 32-bit instruction words
// and writes them into instruction memory starting at address 0. The load ends
// in one of two ways:
//   - the last address (DEPTH-1) is written, or
//   - a HALT_WORD is written first, after which every remaining address up to
//     DEPTH-1 is written with zero.
// The CPU is held in reset (cpu_rst=1) until the memory is fully written.
//
// Ports
//   clk         rising-edge clock, the block's only clock
//   rst         synchronous, active-high reset
//   start       single-cycle request to begin a load (honoured in IDLE/DONE)
//   byte_valid  byte_data carries a valid byte
//   byte_data   program byte stream, byte 0 of each word is the LSB
//   byte_ready  loader can accept a byte this cycle
//   wr_en       instruction-memory write strobe
//   wr_addr     instruction-memory word address
//   wr_data     instruction word to write (0 whenever wr_en=0)
//   busy        load in progress
//   done        memory fully written
//   cpu_rst     holds the CPU in reset while high
//
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH     = 32,
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = 32'h0000007F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_w;
    logic              byte_accept;
    logic              clear_word;

    // byte_ready is exactly "state is RECV", so this is the handshake.
    assign byte_accept = (state_q == S_RECV) && byte_valid;

    // Start every word from a clean assembly register whenever RECV is entered.
    assign clear_word = (state_d == S_RECV) && (state_q != S_RECV);

    // One byte lane per word byte; lane gi captures the byte while cnt_q==gi.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (rst || clear_word) begin
                lane_q <= '0;
            end else if (byte_accept && (cnt_q == 2'(gi))) begin
                lane_q <= byte_data;
            end
        end

        assign word_w[8*gi +: 8] = lane_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RECV;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_RECV: begin
                if (byte_valid) begin
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                // Reaching the last address ends the load even for a halt word,
                // so the address never wraps.
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else if (word_w == HALT_WORD) begin
                    state_d = S_FILL;
                    addr_d  = addr_q + ADDR_W'(1);
                end else begin
                    state_d = S_RECV;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_ready = (state_q == S_RECV);
    assign wr_en      = (state_q == S_WRITE) || (state_q == S_FILL);
    assign wr_addr    = addr_q;
    assign wr_data    = (state_q == S_WRITE) ? word_w : 32'h0;
    assign busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_FILL);
    assign done       = (state_q == S_DONE);
    assign cpu_rst    = (state_q != S_DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32: number of instruction-memory words written per load.
REQ-002 Parameter ADDR_W, default 5: write-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Parameter HALT_WORD, default 32'h0000007F: end-of-program instruction word.
REQ-004 Ports SHALL be: clk  in  1  rising-edge clock, the block's only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a load.
REQ-007 byte_valid  in  1  byte_data carries a valid byte.
REQ-008 byte_data  in  8  program byte stream, little-endian within each word.
REQ-009 byte_ready  out  1  loader can accept a byte this cycle.
REQ-010 wr_en  out  1  instruction-memory write strobe.
REQ-011 wr_addr  out  ADDR_W  instruction-memory word address.
REQ-012 wr_data  out  32  instruction word to write.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  memory fully written.
REQ-015 cpu_rst  out  1  holds the CPU in reset while high.

Function
REQ-016 States SHALL be IDLE, RECV, WRITE, FILL, DONE, held in a registered state variable.
REQ-017 IDLE: start=1 -> RECV, with word address and byte count cleared to 0; start is ignored in RECV, WRITE and FILL.
REQ-018 A byte SHALL be accepted only on a cycle where byte_valid=1 and byte_ready=1; byte_ready=1 only in RECV.
REQ-019 Byte k of a word (k=0..3) SHALL go into bits [8k+7:8k]; byte 0 is the LSB.
REQ-020 After the 4th byte is accepted, the next cycle SHALL be WRITE, with byte_ready=0.
REQ-021 WRITE SHALL last exactly one cycle: wr_en=1, wr_addr=current address, wr_data=assembled word.
REQ-022 From WRITE: if word==HALT_WORD and address<DEPTH-1 -> FILL, with address+1.
REQ-023 From WRITE: if address==DEPTH-1 -> DONE, whatever the word.
REQ-024 From WRITE: otherwise -> RECV, with address+1 and byte count 0.
REQ-025 FILL SHALL write wr_data=0 with wr_en=1 at one address per cycle, incrementing, through address DEPTH-1 inclusive, then go to DONE.
REQ-026 Address SHALL never wrap; no write beyond DEPTH-1 SHALL occur.
REQ-027 wr_en SHALL be 0 in IDLE, RECV and DONE; wr_data SHALL be 0 whenever wr_en=0.
REQ-028 busy=1 in RECV, WRITE and FILL; done=1 only in DONE.
REQ-029 cpu_rst=1 in every state except DONE; cpu_rst=0 in DONE.
REQ-030 DONE: start=1 -> RECV (reload) with address and byte count cleared; cpu_rst rises in that same next cycle.
REQ-031 Outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path except none.
REQ-032 byte_valid while byte_ready=0 SHALL be ignored; no byte is lost or double-counted.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, address 0, byte count 0 and the assembly register 0.
REQ-034 Values after reset: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cpu_rst=1.
REQ-035 rst SHALL take priority over start and byte_valid, including in the middle of a word or in FILL; any partial word is discarded and no write issues after the reset edge.

Verification
REQ-036 Bench: reset, start, bytes 13 05 60 00 -> wr_en one cycle later, wr_addr=0, wr_data=32'h00600513, then byte_ready=1 again.
REQ-037 Bench: load 3 words, the 3rd =32'h0000007F -> writes at addrs 0..2, FILL writes 0 to addrs 3..31 (29 cycles), then done=1, cpu_rst=0.
REQ-038 Bench: 32 non-halt words, byte_valid toggled randomly -> exactly 32 writes at addrs 0..31 with matching data, no wrap, done=1.
REQ-039 Bench: rst asserted after 2 bytes of word 5 -> IDLE next cycle, wr_en=0, outputs per REQ-034; a fresh start then writes from addr 0.
REQ-040 Bench: start during RECV and FILL -> no effect; start in DONE -> cpu_rst=1, busy=1 next cycle, reload begins at addr 0.
REQ-041 Bench: byte_valid held high in IDLE, WRITE and DONE -> no byte consumed, no write issued.
